// File: rtl/cpu_pkg.sv
// Shared constants, ALU opcodes and the ID/EX slot layout for the 8-bit pipelined core.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int REG_AW = 2;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] ALU_PASS_B = 4'b0000;
    localparam logic [OP_W-1:0] ALU_ADD    = 4'b0001;
    localparam logic [OP_W-1:0] ALU_LOAD_A = 4'b1110;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   opcode;
        logic [REG_AW-1:0] ra;
        logic [REG_AW-1:0] rb;
        logic              use_a;
        logic              use_b;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_AW-1:0] rdst;
        logic              wr_en;
        logic              mem_rd;
    } ex_slot_t;

    // A bubble is PASS_B with no write so it can never disturb CCR or the register file.
    localparam ex_slot_t EX_BUBBLE = '{
        valid:  1'b0,
        opcode: ALU_PASS_B,
        ra:     2'b00,
        rb:     2'b00,
        use_a:  1'b0,
        use_b:  1'b0,
        a:      8'h00,
        b:      8'h00,
        rdst:   2'b00,
        wr_en:  1'b0,
        mem_rd: 1'b0
    };

    function automatic logic writer_hit(input logic wr_en,
                                        input logic [REG_AW-1:0] rdst,
                                        input logic [REG_AW-1:0] src);
        return wr_en & (rdst == src);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand bypass select: EX/MEM beats MEM/WB beats the latched register-file value.
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [REG_AW-1:0] src_i,
    input  logic              use_i,
    input  logic [DATA_W-1:0] raw_i,
    input  logic              exmem_wr_en_i,
    input  logic [REG_AW-1:0] exmem_rdst_i,
    input  logic [DATA_W-1:0] exmem_data_i,
    input  logic              memwb_wr_en_i,
    input  logic [REG_AW-1:0] memwb_rdst_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    output logic [DATA_W-1:0] operand_o
);

    // Operand source selection
    always_comb begin
        operand_o = raw_i;
        if (!use_i) begin
            operand_o = raw_i;
        end else if (writer_hit(exmem_wr_en_i, exmem_rdst_i, src_i)) begin
            operand_o = exmem_data_i;
        end else if (writer_hit(memwb_wr_en_i, memwb_rdst_i, src_i)) begin
            operand_o = memwb_data_i;
        end else begin
            operand_o = raw_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW hazard handling. Define FWD_EN for bypassing with
// load-use stall only; otherwise decode stalls until every pending writer has retired.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [OP_W-1:0]   id_opcode,
    input  logic [REG_AW-1:0] id_ra,
    input  logic [REG_AW-1:0] id_rb,
    input  logic              id_use_a,
    input  logic              id_use_b,
    input  logic [DATA_W-1:0] id_a,
    input  logic [DATA_W-1:0] id_b,
    input  logic [REG_AW-1:0] id_rdst,
    input  logic              id_wr_en,
    input  logic              id_mem_rd,
    output logic              id_ready,
    input  logic              flush,
    input  logic              exmem_wr_en,
    input  logic [REG_AW-1:0] exmem_rdst,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic              memwb_wr_en,
    input  logic [REG_AW-1:0] memwb_rdst,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_A,
    output logic [DATA_W-1:0] ex_B,
    output logic [OP_W-1:0]   ex_opcode,
    output logic [REG_AW-1:0] ex_rdst,
    output logic              ex_wr_en,
    output logic              ex_mem_rd
);

    ex_slot_t slot_q;
    ex_slot_t slot_d;
    logic     stall_s;

`ifdef FWD_EN
    logic     ex_load_s;

    // Only a load in EX cannot be bypassed: its data appears after MEM.
    always_comb begin
        ex_load_s = slot_q.valid & slot_q.mem_rd & slot_q.wr_en;
        stall_s   = ex_load_s & id_valid &
                    ((id_use_a & (id_ra == slot_q.rdst)) |
                     (id_use_b & (id_rb == slot_q.rdst)));
    end

    fwd_mux u_fwd_a (
        .src_i         (slot_q.ra),
        .use_i         (slot_q.use_a),
        .raw_i         (slot_q.a),
        .exmem_wr_en_i (exmem_wr_en),
        .exmem_rdst_i  (exmem_rdst),
        .exmem_data_i  (exmem_data),
        .memwb_wr_en_i (memwb_wr_en),
        .memwb_rdst_i  (memwb_rdst),
        .memwb_data_i  (memwb_data),
        .operand_o     (ex_A)
    );

    fwd_mux u_fwd_b (
        .src_i         (slot_q.rb),
        .use_i         (slot_q.use_b),
        .raw_i         (slot_q.b),
        .exmem_wr_en_i (exmem_wr_en),
        .exmem_rdst_i  (exmem_rdst),
        .exmem_data_i  (exmem_data),
        .memwb_wr_en_i (memwb_wr_en),
        .memwb_rdst_i  (memwb_rdst),
        .memwb_data_i  (memwb_data),
        .operand_o     (ex_B)
    );
`else
    logic busy_a_s;
    logic busy_b_s;
    logic unused_s;

    // Without bypassing, any in-flight writer of a used source blocks decode.
    always_comb begin
        busy_a_s = writer_hit(slot_q.valid & slot_q.wr_en, slot_q.rdst, id_ra) |
                   writer_hit(exmem_wr_en, exmem_rdst, id_ra) |
                   writer_hit(memwb_wr_en, memwb_rdst, id_ra);
        busy_b_s = writer_hit(slot_q.valid & slot_q.wr_en, slot_q.rdst, id_rb) |
                   writer_hit(exmem_wr_en, exmem_rdst, id_rb) |
                   writer_hit(memwb_wr_en, memwb_rdst, id_rb);
        stall_s  = id_valid & ((id_use_a & busy_a_s) | (id_use_b & busy_b_s));
    end

    assign ex_A     = slot_q.a;
    assign ex_B     = slot_q.b;
    assign unused_s = ^{exmem_data, memwb_data, slot_q.ra, slot_q.rb,
                        slot_q.use_a, slot_q.use_b};
`endif

    // Decode handshake; flush overrides a pending stall.
    always_comb begin
        if (rst) begin
            id_ready = 1'b1;
        end else if (flush) begin
            id_ready = 1'b1;
        end else begin
            id_ready = ~stall_s;
        end
    end

    // Next slot contents: flush > stall > capture.
    always_comb begin
        slot_d = EX_BUBBLE;
        if (flush) begin
            slot_d = EX_BUBBLE;
        end else if (stall_s) begin
            slot_d = EX_BUBBLE;
        end else if (id_valid) begin
            slot_d = '{
                valid:  1'b1,
                opcode: id_opcode,
                ra:     id_ra,
                rb:     id_rb,
                use_a:  id_use_a,
                use_b:  id_use_b,
                a:      id_a,
                b:      id_b,
                rdst:   id_rdst,
                wr_en:  id_wr_en,
                mem_rd: id_mem_rd
            };
        end else begin
            slot_d = EX_BUBBLE;
        end
    end

    // ID/EX slot register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= EX_BUBBLE;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign ex_valid  = slot_q.valid;
    assign ex_opcode = slot_q.opcode;
    assign ex_rdst   = slot_q.rdst;
    assign ex_wr_en  = slot_q.wr_en;
    assign ex_mem_rd = slot_q.mem_rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed checks of id_ex_stage against an instruction-level reference model.
module tb_id_ex_stage;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_opcode;
    logic [1:0] id_ra, id_rb;
    logic       id_use_a, id_use_b;
    logic [7:0] id_a, id_b;
    logic [1:0] id_rdst;
    logic       id_wr_en, id_mem_rd;
    logic       id_ready;
    logic       flush;
    logic       exmem_wr_en;
    logic [1:0] exmem_rdst;
    logic [7:0] exmem_data;
    logic       memwb_wr_en;
    logic [1:0] memwb_rdst;
    logic [7:0] memwb_data;
    logic       ex_valid;
    logic [7:0] ex_A, ex_B;
    logic [3:0] ex_opcode;
    logic [1:0] ex_rdst;
    logic       ex_wr_en, ex_mem_rd;

    int err_cnt = 0;
    int chk_cnt = 0;

    typedef struct packed {
        bit       v;
        bit [3:0] op;
        bit [1:0] ra, rb;
        bit       ua, ub;
        bit [7:0] a, b;
        bit [1:0] rd;
        bit       we, mr;
    } instr_t;

    instr_t m;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_ra(id_ra), .id_rb(id_rb), .id_use_a(id_use_a), .id_use_b(id_use_b),
        .id_a(id_a), .id_b(id_b), .id_rdst(id_rdst), .id_wr_en(id_wr_en),
        .id_mem_rd(id_mem_rd), .id_ready(id_ready), .flush(flush),
        .exmem_wr_en(exmem_wr_en), .exmem_rdst(exmem_rdst), .exmem_data(exmem_data),
        .memwb_wr_en(memwb_wr_en), .memwb_rdst(memwb_rdst), .memwb_data(memwb_data),
        .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_opcode(ex_opcode),
        .ex_rdst(ex_rdst), .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit reg_pending(input bit [1:0] r);
        bit ex_w, mem_w, wb_w;
        ex_w  = m.v && m.we && (m.rd == r);
        mem_w = exmem_wr_en && (exmem_rdst == r);
        wb_w  = memwb_wr_en && (memwb_rdst == r);
`ifdef FWD_EN
        return ex_w && m.mr;
`else
        return ex_w || mem_w || wb_w;
`endif
    endfunction

    function automatic bit model_stall();
        return id_valid && ((id_use_a && reg_pending(id_ra)) || (id_use_b && reg_pending(id_rb)));
    endfunction

    function automatic bit [7:0] model_operand(input bit u, input bit [1:0] r, input bit [7:0] raw);
`ifdef FWD_EN
        if (u && exmem_wr_en && exmem_rdst == r) return exmem_data;
        if (u && memwb_wr_en && memwb_rdst == r) return memwb_data;
`endif
        return raw;
    endfunction

    // Check all outputs, then advance one clock and update the model.
    task automatic tick(input string tag);
        bit exp_ready;
        #1;
        if (rst) m = '0;
        exp_ready = rst || flush || !model_stall();
        chk({tag, ".valid"}, ex_valid, m.v);
        chk({tag, ".op"}, ex_opcode, m.op);
        chk({tag, ".rdst"}, ex_rdst, m.rd);
        chk({tag, ".we"}, ex_wr_en, m.we);
        chk({tag, ".mr"}, ex_mem_rd, m.mr);
        chk({tag, ".A"}, ex_A, model_operand(m.ua, m.ra, m.a));
        chk({tag, ".B"}, ex_B, model_operand(m.ub, m.rb, m.b));
        chk({tag, ".ready"}, id_ready, exp_ready);
        @(posedge clk);
        if (rst || flush || model_stall() || !id_valid) begin
            m = '0;
        end else begin
            m = '{v: 1'b1, op: id_opcode, ra: id_ra, rb: id_rb, ua: id_use_a, ub: id_use_b,
                  a: id_a, b: id_b, rd: id_rdst, we: id_wr_en, mr: id_mem_rd};
        end
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 1'b0; id_opcode = 4'h0; id_ra = 2'd0; id_rb = 2'd0;
        id_use_a = 1'b0; id_use_b = 1'b0; id_a = 8'h00; id_b = 8'h00;
        id_rdst = 2'd0; id_wr_en = 1'b0; id_mem_rd = 1'b0; flush = 1'b0;
        exmem_wr_en = 1'b0; exmem_rdst = 2'd0; exmem_data = 8'h00;
        memwb_wr_en = 1'b0; memwb_rdst = 2'd0; memwb_data = 8'h00;
    endtask

    task automatic set_id(input bit [3:0] op, input bit [1:0] ra, input bit [1:0] rb,
                          input bit ua, input bit ub, input bit [7:0] a, input bit [7:0] b,
                          input bit [1:0] rd, input bit we, input bit mr);
        id_valid = 1'b1; id_opcode = op; id_ra = ra; id_rb = rb;
        id_use_a = ua; id_use_b = ub; id_a = a; id_b = b;
        id_rdst = rd; id_wr_en = we; id_mem_rd = mr;
    endtask

    initial begin
        int stall_cycles;
        m = '0;
        idle();
        rst = 1'b1;
        @(negedge clk);
        tick("reset");
        rst = 1'b0;

        // ADD capture, one-cycle latency
        set_id(4'b0001, 2'd1, 2'd2, 1'b1, 1'b1, 8'h05, 8'h03, 2'd3, 1'b1, 1'b0);
        tick("add_cap");
        idle();
        #1;
        chk("add.A", ex_A, 8'h05);
        chk("add.B", ex_B, 8'h03);
        chk("add.op", ex_opcode, 4'b0001);

        // Asynchronous reset while the slot is valid
        #1 rst = 1'b1;
        #1;
        chk("rst_mid.valid", ex_valid, 1'b0);
        chk("rst_mid.op", ex_opcode, 4'b0000);
        chk("rst_mid.we", ex_wr_en, 1'b0);
        chk("rst_mid.ready", id_ready, 1'b1);
        tick("rst_mid");
        rst = 1'b0;
        tick("post_rst");

        // Flush while a hazard would stall
        set_id(4'b1110, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd1, 1'b1, 1'b1);
        tick("ld_cap");
        set_id(4'b0001, 2'd1, 2'd1, 1'b1, 1'b0, 8'h22, 8'h00, 2'd2, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        chk("flush.ready", id_ready, 1'b1);
        tick("flush");
        idle();
        #1;
        chk("flush.valid", ex_valid, 1'b0);
        chk("flush.we", ex_wr_en, 1'b0);
        tick("flush_after");

`ifdef FWD_EN
        // EX/MEM beats MEM/WB
        set_id(4'b0001, 2'd0, 2'd2, 1'b1, 1'b1, 8'h01, 8'h00, 2'd3, 1'b1, 1'b0);
        tick("fwd_cap");
        idle();
        exmem_wr_en = 1'b1; exmem_rdst = 2'd2; exmem_data = 8'h7F;
        memwb_wr_en = 1'b1; memwb_rdst = 2'd2; memwb_data = 8'h11;
        #1;
        chk("fwd.B", ex_B, 8'h7F);
        tick("fwd");
        idle();

        // Load-use: one bubble, then operand from MEM/WB
        set_id(4'b1110, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd1, 1'b1, 1'b1);
        tick("lu_ld");
        set_id(4'b0001, 2'd1, 2'd3, 1'b1, 1'b0, 8'h99, 8'h00, 2'd2, 1'b1, 1'b0);
        #1;
        chk("lu.stall", id_ready, 1'b0);
        tick("lu_stall");
        #1;
        chk("lu.ready", id_ready, 1'b1);
        chk("lu.bubble", ex_valid, 1'b0);
        tick("lu_cap");
        idle();
        memwb_wr_en = 1'b1; memwb_rdst = 2'd1; memwb_data = 8'h5A;
        #1;
        chk("lu.A", ex_A, 8'h5A);
        tick("lu_fwd");
        idle();
`else
        // Back-to-back dependency drains through EX, EX/MEM and MEM/WB
        set_id(4'b0001, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd1, 1'b1, 1'b0);
        tick("dep_w");
        stall_cycles = 0;
        set_id(4'b0001, 2'd1, 2'd2, 1'b1, 1'b1, 8'h42, 8'h07, 2'd2, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            exmem_wr_en = (c == 1); exmem_rdst = 2'd1;
            memwb_wr_en = (c == 2); memwb_rdst = 2'd1;
            #1;
            if (!id_ready) stall_cycles++;
            tick("dep");
        end
        idle();
        #1;
        chk("dep.stalls", stall_cycles, 3);
        chk("dep.valid", ex_valid, 1'b1);
        chk("dep.A", ex_A, 8'h42);
        tick("dep_done");
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_opcode = 4'($urandom);
            id_ra = 2'($urandom); id_rb = 2'($urandom);
            id_use_a = 1'($urandom); id_use_b = 1'($urandom);
            id_a = 8'($urandom); id_b = 8'($urandom);
            id_rdst = 2'($urandom); id_wr_en = 1'($urandom);
            id_mem_rd = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 9) == 0);
            exmem_wr_en = ($urandom_range(0, 3) == 0);
            exmem_rdst = 2'($urandom); exmem_data = 8'($urandom);
            memwb_wr_en = ($urandom_range(0, 3) == 0);
            memwb_rdst = 2'($urandom); memwb_data = 8'($urandom);
            tick("rand");
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
